// File: rtl/flash_array_read_seq_if.sv
// Command/response channel bundle for the flash array read sequencer.
// Both channels use valid/ready: a transfer happens on the rising clock edge where valid
// and ready are both high; once valid is raised, the payload holds until that edge.
interface flash_array_read_seq_if #(
  parameter int N_BL  = 8,
  parameter int N_BLK = 2,
  parameter int N_WL  = 4
);
  localparam int BW = (N_BLK > 1) ? $clog2(N_BLK) : 1;
  localparam int WW = (N_WL > 1) ? $clog2(N_WL) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [BW-1:0]     cmd_blk;
  logic [WW-1:0]     cmd_wl;
  logic              cmd_mlc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*N_BL-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_blk, cmd_wl, cmd_mlc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_blk, cmd_wl, cmd_mlc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/flash_array_read_seq.sv
// Timed read sequencer for the NAND cell array: select string/word line, precharge,
// one or two sense pulses, discharge, then hand the captured bit-line data back.
module flash_array_read_seq #(
  parameter int N_BL    = 8,
  parameter int N_BLK   = 2,
  parameter int N_WL    = 4,
  parameter int T_PRE   = 4,
  parameter int T_SENSE = 3
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  flash_array_read_seq_if.slave bus,
  input  logic                  abort_i,
  input  logic [N_BL-1:0]       sa_i,
  output logic                  busy_o,
  output logic [N_BLK-1:0]      ssl_o,
  output logic [N_BLK-1:0]      gsl_o,
  output logic [N_BLK*N_WL-1:0] wl_sel_o,
  output logic [N_BLK*N_WL-1:0] wl_pass_o,
  output logic                  sen1_o,
  output logic                  sen2_o,
  output logic                  out_en_o,
  output logic [2:0]            dbg_state_o
);
  localparam int BW    = (N_BLK > 1) ? $clog2(N_BLK) : 1;
  localparam int WW    = (N_WL > 1) ? $clog2(N_WL) : 1;
  localparam int T_MAX = (T_PRE > T_SENSE) ? T_PRE : T_SENSE;
  localparam int CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PRE   = 3'd2,
    S_SEN1  = 3'd3,
    S_SEN2  = 3'd4,
    S_DISCH = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   blk_q;
  logic [WW-1:0]   wl_q;
  logic            mlc_q;
  logic            bad_q;

  logic            accept;
  logic            cmd_bad;
  logic            active;
  logic            abort_hit;
  logic            last_phase;
  logic [BW-1:0]   blk_n;
  logic [WW-1:0]   wl_n;
  logic            bad_n;
  logic            ctl_on;
  logic [N_BLK-1:0]      ssl_n;
  logic [N_BLK*N_WL-1:0] sel_n;
  logic [N_BLK*N_WL-1:0] pass_n;

  assign dbg_state_o = state;

  always_comb begin
    accept     = (state == S_IDLE) && bus.cmd_valid && bus.cmd_ready;
    cmd_bad    = (int'(bus.cmd_blk) >= N_BLK) || (int'(bus.cmd_wl) >= N_WL);
    active     = state inside {S_SETUP, S_PRE, S_SEN1, S_SEN2};
    // A bad-address command already heads for an error response; abort adds nothing.
    abort_hit  = active && abort_i && !((state == S_SETUP) && bad_q);
    last_phase = (cnt == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SETUP;
      S_SETUP: begin
        if (bad_q)          state_nxt = S_RESP;
        else if (abort_hit) state_nxt = S_DISCH;
        else                state_nxt = S_PRE;
      end
      S_PRE: begin
        if (abort_hit)       state_nxt = S_DISCH;
        else if (last_phase) state_nxt = S_SEN1;
      end
      S_SEN1: begin
        if (abort_hit)       state_nxt = S_DISCH;
        else if (last_phase) state_nxt = mlc_q ? S_SEN2 : S_DISCH;
      end
      S_SEN2: begin
        if (abort_hit)       state_nxt = S_DISCH;
        else if (last_phase) state_nxt = S_DISCH;
      end
      S_DISCH: state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_valid && bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Array controls are registered from the next state, so the address being accepted
  // this edge must be used directly rather than the latched copy.
  always_comb begin
    blk_n  = accept ? bus.cmd_blk : blk_q;
    wl_n   = accept ? bus.cmd_wl  : wl_q;
    bad_n  = accept ? cmd_bad     : bad_q;
    ctl_on = (state_nxt inside {S_SETUP, S_PRE, S_SEN1, S_SEN2}) && !bad_n;
    ssl_n  = '0;
    sel_n  = '0;
    pass_n = '0;
    for (int b = 0; b < N_BLK; b++) begin
      if (ctl_on && (int'(blk_n) == b)) begin
        ssl_n[b] = 1'b1;
        for (int w = 0; w < N_WL; w++) begin
          if (int'(wl_n) == w) sel_n[b*N_WL+w]  = 1'b1;
          else                 pass_n[b*N_WL+w] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state         <= S_IDLE;
      cnt           <= '0;
      blk_q         <= '0;
      wl_q          <= '0;
      mlc_q         <= 1'b0;
      bad_q         <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      busy_o        <= 1'b0;
      ssl_o         <= '0;
      gsl_o         <= '0;
      wl_sel_o      <= '0;
      wl_pass_o     <= '0;
      sen1_o        <= 1'b0;
      sen2_o        <= 1'b0;
      out_en_o      <= 1'b0;
    end else begin
      state <= state_nxt;

      // Phase counter reloads on entry and parks at zero.
      if (state_nxt != state) begin
        case (state_nxt)
          S_PRE:          cnt <= CW'(T_PRE - 1);
          S_SEN1, S_SEN2: cnt <= CW'(T_SENSE - 1);
          default:        cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      if (accept) begin
        blk_q        <= bus.cmd_blk;
        wl_q         <= bus.cmd_wl;
        mlc_q        <= bus.cmd_mlc;
        bad_q        <= cmd_bad;
        bus.rsp_data <= '0;
        bus.rsp_err  <= 1'b0;
      end else if (abort_hit) begin
        bus.rsp_data <= '0;
        bus.rsp_err  <= 1'b1;
      end else if ((state == S_SETUP) && bad_q) begin
        bus.rsp_err  <= 1'b1;
      end else if ((state == S_SEN1) && last_phase) begin
        bus.rsp_data[N_BL-1:0] <= sa_i;
      end else if ((state == S_SEN2) && last_phase) begin
        bus.rsp_data[2*N_BL-1:N_BL] <= sa_i;
      end

      bus.cmd_ready <= (state_nxt == S_IDLE);
      bus.rsp_valid <= (state_nxt == S_RESP);
      busy_o        <= (state_nxt != S_IDLE);
      ssl_o         <= ssl_n;
      gsl_o         <= ssl_n;
      wl_sel_o      <= sel_n;
      wl_pass_o     <= pass_n;
      sen1_o        <= (state_nxt == S_SEN1);
      sen2_o        <= (state_nxt == S_SEN2);
      out_en_o      <= (state_nxt == S_SEN1) || (state_nxt == S_SEN2);
    end
  end
endmodule

// File: tb/tb_flash_array_read_seq.sv
// Bench for flash_array_read_seq: default-size instance for timed reads, plus a
// three-word-line instance so that an out-of-range word line can be commanded.
module tb_flash_array_read_seq;
  localparam int TP = 4;
  localparam int TS = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- DUT A (defaults) ----------------
  flash_array_read_seq_if #(.N_BL(8), .N_BLK(2), .N_WL(4)) if_a ();
  logic       abort_a;
  logic [7:0] sa_a;
  logic       busy_a, sen1_a, sen2_a, oe_a;
  logic [1:0] ssl_a, gsl_a;
  logic [7:0] sel_a, pass_a;
  logic [2:0] dbg_a;

  flash_array_read_seq #(.N_BL(8), .N_BLK(2), .N_WL(4), .T_PRE(TP), .T_SENSE(TS)) dut_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(if_a), .abort_i(abort_a), .sa_i(sa_a),
    .busy_o(busy_a), .ssl_o(ssl_a), .gsl_o(gsl_a), .wl_sel_o(sel_a), .wl_pass_o(pass_a),
    .sen1_o(sen1_a), .sen2_o(sen2_a), .out_en_o(oe_a), .dbg_state_o(dbg_a)
  );

  logic [25:0] ctl_a;
  assign ctl_a = {ssl_a, gsl_a, sel_a, pass_a, sen1_a, sen2_a, oe_a,
                  busy_a, if_a.cmd_ready, if_a.rsp_valid};

  // ---------------- DUT B (N_WL=3) ----------------
  flash_array_read_seq_if #(.N_BL(8), .N_BLK(2), .N_WL(3)) if_b ();
  logic       abort_b;
  logic [7:0] sa_b;
  logic       busy_b, sen1_b, sen2_b, oe_b;
  logic [1:0] ssl_b, gsl_b;
  logic [5:0] sel_b, pass_b;
  logic [2:0] dbg_b;

  flash_array_read_seq #(.N_BL(8), .N_BLK(2), .N_WL(3), .T_PRE(TP), .T_SENSE(TS)) dut_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(if_b), .abort_i(abort_b), .sa_i(sa_b),
    .busy_o(busy_b), .ssl_o(ssl_b), .gsl_o(gsl_b), .wl_sel_o(sel_b), .wl_pass_o(pass_b),
    .sen1_o(sen1_b), .sen2_o(sen2_b), .out_en_o(oe_b), .dbg_state_o(dbg_b)
  );

  logic [21:0] ctl_b;
  assign ctl_b = {ssl_b, gsl_b, sel_b, pass_b, sen1_b, sen2_b, oe_b,
                  busy_b, if_b.cmd_ready, if_b.rsp_valid};

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  int          cyc_q[$];
  logic [16:0] exp_b_q[$];
  int          cyc_b_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor A: first cycle of each response pops the queue; later cycles check stability.
  initial begin
    logic [16:0] cur;
    int          ec;
    bit          have;
    have = 0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !if_a.rsp_valid) have = 0;
      else if (!have) begin
        if (exp_q.size() == 0) chk("a_rsp_unexpected", 64'(if_a.rsp_valid), 64'd0);
        else begin
          cur  = exp_q.pop_front();
          ec   = cyc_q.pop_front();
          have = 1;
          chk("a_rsp_data", {if_a.rsp_err, if_a.rsp_data}, cur);
          chk("a_rsp_latency", cyc, ec);
        end
      end else chk("a_rsp_hold", {if_a.rsp_err, if_a.rsp_data}, cur);
    end
  end

  initial begin
    logic [16:0] cur;
    int          ec;
    bit          have;
    have = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !if_b.rsp_valid) have = 0;
      else if (!have) begin
        if (exp_b_q.size() == 0) chk("b_rsp_unexpected", 64'(if_b.rsp_valid), 64'd0);
        else begin
          cur  = exp_b_q.pop_front();
          ec   = cyc_b_q.pop_front();
          have = 1;
          chk("b_rsp_data", {if_b.rsp_err, if_b.rsp_data}, cur);
          chk("b_rsp_latency", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input string name, input logic blk, input logic [1:0] wl,
                         input logic mlc, input logic [7:0] sa1, input logic [7:0] sa2,
                         input logic [1:0] e_ssl, input logic [7:0] e_sel,
                         input logic [7:0] e_pass, input logic [15:0] e_data,
                         input logic e_err, input int lat, input int abort_at,
                         input int hold, input int rst_at);
    int act_end, s1_last, s2_last, n, t;
    logic a, s1, s2;
    logic [25:0] e;
    act_end = (abort_at >= 0) ? abort_at : lat - 2;
    s1_last = TP + TS;
    s2_last = TP + 2 * TS;
    t = 0;
    while (!if_a.cmd_ready && t < 32) begin
      @(negedge clk);
      t++;
    end
    if (!if_a.cmd_ready) begin
      chk({name, "_ready_timeout"}, 64'(if_a.cmd_ready), 64'd1);
      return;
    end
    if_a.rsp_ready = (hold == 0);
    if_a.cmd_valid = 1'b1;
    if_a.cmd_blk   = blk;
    if_a.cmd_wl    = wl;
    if_a.cmd_mlc   = mlc;
    for (int j = 0; j < lat; j++) begin
      @(negedge clk);
      if (j == 0) begin
        if_a.cmd_valid = 1'b0;
        exp_q.push_back({e_err, e_data});
        cyc_q.push_back(cyc + lat);
      end
      a  = (j <= act_end);
      s1 = a && (j > s1_last - TS) && (j <= s1_last);
      s2 = a && mlc && (j > s2_last - TS) && (j <= s2_last);
      e  = {a ? e_ssl : 2'b0, a ? e_ssl : 2'b0, a ? e_sel : 8'h0, a ? e_pass : 8'h0,
            s1, s2, s1 | s2, 1'b1, 1'b0, 1'b0};
      chk($sformatf("%s_ctl_j%0d", name, j), ctl_a, e);
      if (j == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({name, "_async_rst"},
            {ctl_a, dbg_a, if_a.rsp_err, if_a.rsp_data}, 64'd0);
        exp_q.delete();
        cyc_q.delete();
        abort_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk({name, "_ready_in_rst"}, 64'(if_a.cmd_ready), 64'd0);
        @(negedge clk);
        chk({name, "_ready_after_rst"}, ctl_a, 26'b010);
        if_a.rsp_ready = 1'b1;
        return;
      end
      abort_a = (j == abort_at);
      sa_a = (j == s1_last) ? sa1 : ((mlc && j == s2_last) ? sa2 : 8'($urandom_range(0, 255)));
    end
    abort_a = 1'b0;
    n = (hold > 0) ? hold : 1;
    for (int h = 0; h < n; h++) begin
      @(negedge clk);
      chk($sformatf("%s_resp_h%0d", name, h), ctl_a, 26'b101);
      abort_a = (h == 1);
      if (h == n - 1) if_a.rsp_ready = 1'b1;
    end
    abort_a = 1'b0;
    @(negedge clk);
    chk({name, "_idle"}, ctl_a, 26'b010);
  endtask

  task automatic do_bad_b(input string name, input logic blk, input logic [1:0] wl);
    int t;
    t = 0;
    while (!if_b.cmd_ready && t < 32) begin
      @(negedge clk);
      t++;
    end
    if (!if_b.cmd_ready) begin
      chk({name, "_ready_timeout"}, 64'(if_b.cmd_ready), 64'd1);
      return;
    end
    if_b.rsp_ready = 1'b1;
    if_b.cmd_valid = 1'b1;
    if_b.cmd_blk   = blk;
    if_b.cmd_wl    = wl;
    if_b.cmd_mlc   = 1'b0;
    @(negedge clk);
    if_b.cmd_valid = 1'b0;
    exp_b_q.push_back(17'h10000);
    cyc_b_q.push_back(cyc + 1);
    chk({name, "_setup"}, ctl_b, 22'b100);
    @(negedge clk);
    chk({name, "_resp"}, ctl_b, 22'b101);
    @(negedge clk);
    chk({name, "_idle"}, ctl_b, 22'b010);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if_a.cmd_valid = 1'b0; if_a.cmd_blk = '0; if_a.cmd_wl = '0; if_a.cmd_mlc = 1'b0;
    if_a.rsp_ready = 1'b1;
    if_b.cmd_valid = 1'b0; if_b.cmd_blk = '0; if_b.cmd_wl = '0; if_b.cmd_mlc = 1'b0;
    if_b.rsp_ready = 1'b1;
    abort_a = 1'b0; sa_a = 8'h00;
    abort_b = 1'b0; sa_b = 8'h00;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_a", {ctl_a, dbg_a, if_a.rsp_err, if_a.rsp_data}, 64'd0);
    chk("reset_b", {ctl_b, dbg_b, if_b.rsp_err, if_b.rsp_data}, 64'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", 64'(if_a.cmd_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_release_a", ctl_a, 26'b010);
    chk("ready_after_release_b", ctl_b, 22'b010);

    //       name    blk  wl    mlc   sa1    sa2    ssl    sel    pass   data      err  lat abort hold rst
    do_read("slc",   1'b1, 2'd2, 1'b0, 8'hA5, 8'h00, 2'b10, 8'h40, 8'hB0, 16'h00A5, 1'b0, 9, -1, 0, -1);
    do_read("mlc",   1'b0, 2'd1, 1'b1, 8'h3C, 8'hF0, 2'b01, 8'h02, 8'h0D, 16'hF03C, 1'b0, 12, -1, 0, -1);
    do_read("bp",    1'b0, 2'd3, 1'b0, 8'h5A, 8'h00, 2'b01, 8'h08, 8'h07, 16'h005A, 1'b0, 9, -1, 5, -1);
    do_read("abpre", 1'b1, 2'd0, 1'b1, 8'h11, 8'h22, 2'b10, 8'h10, 8'hE0, 16'h0000, 1'b1, 4, 2, 0, -1);
    do_read("mlc2",  1'b1, 2'd3, 1'b1, 8'h7E, 8'h81, 2'b10, 8'h80, 8'h70, 16'h817E, 1'b0, 12, -1, 0, -1);
    do_read("abs1",  1'b0, 2'd0, 1'b0, 8'hFF, 8'h00, 2'b01, 8'h01, 8'h0E, 16'h0000, 1'b1, 9, 7, 0, -1);
    do_read("rst",   1'b1, 2'd1, 1'b0, 8'h99, 8'h00, 2'b10, 8'h20, 8'hD0, 16'h0099, 1'b0, 9, -1, 0, 6);
    do_read("post",  1'b0, 2'd2, 1'b0, 8'hC3, 8'h00, 2'b01, 8'h04, 8'h0B, 16'h00C3, 1'b0, 9, -1, 0, -1);

    do_bad_b("bad_b0", 1'b0, 2'd3);
    do_bad_b("bad_b1", 1'b1, 2'd3);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_b_q_drained", 64'(exp_b_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: got time %0t required finish before it", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end
endmodule
